// File: rtl/comparator_pkg.sv
// Shared definitions for the digit-serial magnitude comparator: FSM state
// encoding, digit-count derivation and the {gt, eq, lt} flag triple.
package comparator_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    localparam int DATA_WIDTH_DEFAULT  = 32;
    localparam int DIGIT_WIDTH_DEFAULT = 8;

    // Number of digits walked per operation; the digit width must divide
    // the operand width exactly.
    function automatic int num_digits(input int data_width, input int digit_width);
        return data_width / digit_width;
    endfunction

    // Width of the digit index register, never narrower than one bit.
    function automatic int idx_width(input int n_digits);
        return (n_digits > 1) ? $clog2(n_digits) : 1;
    endfunction

    localparam int NUM_DIGITS_DEFAULT = num_digits(DATA_WIDTH_DEFAULT, DIGIT_WIDTH_DEFAULT);
    localparam int IDX_WIDTH_DEFAULT  = idx_width(NUM_DIGITS_DEFAULT);

    // Result flags, most significant field first: {gt, eq, lt}.
    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } flags_t;

    localparam flags_t FLAGS_NONE = 3'b000;

endpackage

// File: rtl/comparator_digit.sv
// Combinational unsigned compare of one digit, producing a one-hot
// {gt, eq, lt} triple.
module comparator_digit
    import comparator_pkg::*;
#(
    parameter int DIGIT_WIDTH = 8
) (
    input  logic [DIGIT_WIDTH-1:0] digit_a_i,
    input  logic [DIGIT_WIDTH-1:0] digit_b_i,
    output flags_t                 result_o
);

    assign result_o.gt = (digit_a_i >  digit_b_i);
    assign result_o.eq = (digit_a_i == digit_b_i);
    assign result_o.lt = (digit_a_i <  digit_b_i);

endmodule

// File: rtl/comparator_32_bit_sequential.sv
// Registered digit-serial magnitude comparator with start/ready/done
// handshake. One digit per enabled clock, most significant digit first.
// Optional build macro COMPARATOR_SEQ_EARLY_EXIT_EN: finish at the first
// differing digit instead of always walking every digit.
module comparator_32_bit_sequential
    import comparator_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int DIGIT_WIDTH = DIGIT_WIDTH_DEFAULT
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Start_In,
    output logic                  Ready_Out,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    output logic                  Done_Out,
    output logic                  A_gt_B_Out,
    output logic                  A_eq_B_Out,
    output logic                  A_lt_B_Out
);

    localparam int NUM_DIGITS = num_digits(DATA_WIDTH, DIGIT_WIDTH);
    localparam int IDX_W      = idx_width(NUM_DIGITS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    flags_t                  flags_q, flags_d;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
    // First differing digit's verdict, kept while the remaining digits are
    // walked so later equal digits cannot overwrite it.
    logic                    dec_q, dec_d;
    flags_t                  pend_q, pend_d;
`endif

    // Slice the captured operands into digits for index-based selection.
    logic [DIGIT_WIDTH-1:0]  a_dig [NUM_DIGITS];
    logic [DIGIT_WIDTH-1:0]  b_dig [NUM_DIGITS];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digits
        assign a_dig[gi] = a_q[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
        assign b_dig[gi] = b_q[gi*DIGIT_WIDTH +: DIGIT_WIDTH];
    end

    flags_t digit_res;

    comparator_digit #(
        .DIGIT_WIDTH (DIGIT_WIDTH)
    ) u_digit (
        .digit_a_i (a_dig[idx_q]),
        .digit_b_i (b_dig[idx_q]),
        .result_o  (digit_res)
    );

    // Next-state logic: capture, digit walk, and one-cycle result window.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        flags_d = flags_q;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
        dec_d   = dec_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
                if (Start_In) begin
                    a_d     = Data_A_In;
                    b_d     = Data_B_In;
                    idx_d   = LAST_IDX;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
                    dec_d   = 1'b0;
                    pend_d  = FLAGS_NONE;
`endif
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
                // A differing digit or the last equal digit decides; the
                // digit result triple is already the final flag value.
                if (!digit_res.eq || (idx_q == '0)) begin
                    flags_d = digit_res;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
`else
                if (!digit_res.eq && !dec_q) begin
                    dec_d  = 1'b1;
                    pend_d = digit_res;
                end
                // At digit 0 the remembered verdict wins; otherwise every
                // digit matched so far and this digit settles it.
                if (idx_q == '0) begin
                    flags_d = dec_q ? pend_q : digit_res;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset wins, a low enable freezes everything.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            flags_q <= FLAGS_NONE;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
            dec_q   <= 1'b0;
            pend_q  <= FLAGS_NONE;
`endif
        end else if (Enable_In) begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            flags_q <= flags_d;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
            dec_q   <= dec_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign Ready_Out  = (state_q == IDLE);
    assign Done_Out   = (state_q == DONE);
    assign A_gt_B_Out = flags_q.gt;
    assign A_eq_B_Out = flags_q.eq;
    assign A_lt_B_Out = flags_q.lt;

endmodule

// File: tb/tb_comparator_32_bit_sequential.sv
// Scoreboard bench for comparator_32_bit_sequential: the driver pushes the
// expected flags and latency for each accepted operation, a monitor pops
// and checks on every rising Done_Out.
module tb_comparator_32_bit_sequential;

    localparam int DW = 32;
    localparam int GW = 8;
    localparam int ND = DW / GW;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          start;
    logic          ready;
    logic [DW-1:0] data_a;
    logic [DW-1:0] data_b;
    logic          done;
    logic          gt, eq, lt;

    always #5 clk = ~clk;

    comparator_32_bit_sequential #(
        .DATA_WIDTH  (DW),
        .DIGIT_WIDTH (GW)
    ) dut (
        .Clk_In     (clk),
        .Reset_In   (rst),
        .Enable_In  (en),
        .Start_In   (start),
        .Ready_Out  (ready),
        .Data_A_In  (data_a),
        .Data_B_In  (data_b),
        .Done_Out   (done),
        .A_gt_B_Out (gt),
        .A_eq_B_Out (eq),
        .A_lt_B_Out (lt)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]    flags;
        int unsigned   lat;
        int unsigned   c0;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain unsigned relational operators.
    function automatic logic [2:0] ref_flags(input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    // Reference latency: digits examined before a decision.
    function automatic int unsigned ref_lat(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int unsigned lat;
        lat = ND;
        for (int d = ND - 1; d >= 0; d--) begin
            if (((a >> (d * GW)) & 32'hFF) != ((b >> (d * GW)) & 32'hFF)) begin
                lat = ND - d;
                break;
            end
        end
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
        lat = ND;
`endif
        return lat;
    endfunction

    // Issue one operation; called and returns at a falling edge.
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int stall, input bit junk, input bit push);
        int t;
        t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", {31'd0, ready}, 32'd1);
        start  = 1'b1;
        data_a = a;
        data_b = b;
        if (push) sbq.push_back('{ref_flags(a, b), ref_lat(a, b) + stall, cyc + 1, a, b});
        $display("issue A=%08h B=%08h stall=%0d busy_start=%0d", a, b, stall, junk);
        @(negedge clk);
        // Captured: disturb the operand inputs and optionally keep Start up.
        data_a = ~a;
        data_b = $urandom;
        start  = junk;
        if (stall > 0) begin
            en = 1'b0;
            repeat (stall) @(negedge clk);
            en = 1'b1;
        end
        if (junk) @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: one check set per Done_Out rising edge.
    initial begin : monitor
        bit   done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done && !done_prev) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: got flags %b, expected no Done_Out", {gt, eq, lt});
                end else begin
                    e = sbq.pop_front();
                    $display("done  A=%08h B=%08h flags=%b exp=%b lat=%0d exp_lat=%0d",
                             e.a, e.b, {gt, eq, lt}, e.flags, cyc - e.c0, e.lat);
                    check("flags", {29'd0, gt, eq, lt}, {29'd0, e.flags});
                    check("onehot", $countones({gt, eq, lt}), 32'd1);
                    check("latency", cyc - e.c0, e.lat);
                end
            end
            if (done_prev && !done) check("ready_after_done", {31'd0, ready}, 32'd1);
            done_prev = done;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [DW-1:0] ra, rb;
        int            t;
        rst    = 1'b1;
        en     = 1'b1;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;
        repeat (2) @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_flags", {29'd0, gt, eq, lt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(32'h12345678, 32'h12345678, 0, 0, 1);
        issue(32'h80000000, 32'h7FFFFFFF, 0, 0, 1);
        issue(32'h00000000, 32'h00000001, 0, 0, 1);
        issue(32'hA5000000, 32'h5A000000, 3, 0, 1);
        issue(32'h00001234, 32'h00001200, 0, 1, 1);

        // Reset during a compare: no result may follow.
        t = 0;
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        start  = 1'b1;
        data_a = 32'h00000001;
        data_b = 32'h00000002;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_flags", {29'd0, gt, eq, lt}, 32'd0);
        $display("abort reset applied mid-compare");
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = ra;
                default: rb = ra ^ (32'd1 << $urandom_range(0, 31));
            endcase
            issue(ra, rb, (i % 3 == 0) ? int'($urandom_range(0, 2)) : 0, 0, 1);
        end

        t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("results_outstanding", sbq.size(), 32'd0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
